// File: rtl/systolic_pkg.sv
// Shared state encoding, width helper and default-size vector types for the systolic MAC array.
package systolic_pkg;

  localparam int DEP_DEF  = 8;
  localparam int LEN_DEF  = 4;
  localparam int KMAX_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Full product width plus enough headroom for KMAX accumulations.
  function automatic int accw_f(input int dep, input int kmax);
    return 2 * dep + $clog2(kmax);
  endfunction

  localparam int ACCW_DEF = accw_f(DEP_DEF, KMAX_DEF);

  typedef logic signed [LEN_DEF-1:0][DEP_DEF-1:0]  opvec_t;
  typedef logic signed [LEN_DEF-1:0][ACCW_DEF-1:0] resrow_t;

endpackage

// File: rtl/systolic_mac_array_pe.sv
// Single output-stationary PE: forwards A east and B south, accumulates a*b in place.
// With SYSTOLIC_MAC_SAT_EN the accumulator clips to the signed ACCW range and raises a sticky sat.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DEP  = DEP_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   acc_en,
  input  logic signed [DEP-1:0]  a,
  input  logic signed [DEP-1:0]  b,
  output logic signed [DEP-1:0]  a_east,
  output logic signed [DEP-1:0]  b_south,
  output logic signed [ACCW-1:0] acc
`ifdef SYSTOLIC_MAC_SAT_EN
  ,
  output logic                   sat
`endif
);

  localparam int PW = 2 * DEP;

  logic signed [PW-1:0] prod;
  logic [ACCW:0]        sum_w;

  assign prod = PW'(a) * PW'(b);
  // One guard bit above the accumulator exposes signed overflow of the sum.
  assign sum_w = {acc[ACCW-1], acc} + {{(ACCW + 1 - PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_east  <= '0;
      b_south <= '0;
    end else if (clr) begin
      a_east  <= '0;
      b_south <= '0;
    end else begin
      a_east  <= a;
      b_south <= b;
    end
  end

`ifdef SYSTOLIC_MAC_SAT_EN
  localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW - 1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW - 1){1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (acc_en) begin
      if (sum_w[ACCW] != sum_w[ACCW-1]) begin
        acc <= sum_w[ACCW] ? ACC_MIN : ACC_MAX;
        sat <= 1'b1;
      end else begin
        acc <= sum_w[ACCW-1:0];
      end
    end
  end
`else
  logic unused_guard;
  assign unused_guard = sum_w[ACCW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= sum_w[ACCW-1:0];
    end
  end
`endif

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary LEN x LEN systolic MAC array with clear / run / row-by-row drain sequencing.
// Build with SYSTOLIC_MAC_SAT_EN to saturate accumulators and expose sat_flag.
//   state | meaning
//   IDLE  | waiting for start; an accepted start clears the array and latches K
//   RUN   | feeders enabled, PEs accumulate for K+2*LEN-2 cycles
//   DRAIN | result rows presented, one per res_valid && res_ready
//   DONE  | one-cycle done pulse, then back to IDLE
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter  int DEP  = DEP_DEF,
  parameter  int LEN  = LEN_DEF,
  parameter  int KMAX = KMAX_DEF,
  localparam int ACCW = accw_f(DEP, KMAX),
  localparam int KW   = $clog2(KMAX + 1),
  localparam int IW   = $clog2(LEN)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [KW-1:0]                    k_len,
  output logic                             feed_en,
  input  logic signed [LEN-1:0][DEP-1:0]   a_in,
  input  logic signed [LEN-1:0][DEP-1:0]   b_in,
  output logic                             busy,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic signed [LEN-1:0][ACCW-1:0]  res_row,
  output logic [IW-1:0]                    res_idx,
  output logic                             done
`ifdef SYSTOLIC_MAC_SAT_EN
  ,
  output logic                             sat_flag
`endif
);

  localparam int CW = $clog2(KMAX + 2 * LEN);

  state_t          state, state_nxt;
  logic            clr, acc_en;
  logic [CW-1:0]   cyc_cnt, run_last;
  logic [IW-1:0]   row;
  logic [KW-1:0]   k_eff;

  logic signed [DEP-1:0]  a_w   [LEN][LEN+1];
  logic signed [DEP-1:0]  b_w   [LEN+1][LEN];
  logic signed [ACCW-1:0] acc_w [LEN][LEN];

  assign k_eff = (k_len == '0) ? KW'(1) : k_len;

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    acc_en    = 1'b0;
    feed_en   = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        feed_en = 1'b1;
        acc_en  = 1'b1;
        if (cyc_cnt == run_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        res_valid = 1'b1;
        if (res_ready && row == IW'(LEN - 1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      run_last <= '0;
      row      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        // Last cycle in which the far corner PE still sees a valid beat.
        run_last <= CW'(k_eff) + CW'(2 * LEN - 3);
        cyc_cnt  <= '0;
        row      <= '0;
      end else if (state == RUN) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      if (state == DRAIN && res_ready) begin
        row <= (row == IW'(LEN - 1)) ? '0 : row + 1'b1;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign res_idx = row;

  always_comb begin
    res_row = '0;
    if (state == DRAIN) begin
      for (int j = 0; j < LEN; j++) res_row[j] = acc_w[row][j];
    end
  end

`ifdef SYSTOLIC_MAC_SAT_EN
  logic [LEN*LEN-1:0] sat_bits;
  assign sat_flag = |sat_bits;
`endif

  for (genvar i = 0; i < LEN; i++) begin : g_row
    assign a_w[i][0] = a_in[i];
    assign b_w[0][i] = b_in[i];

    // Operands leaving the east and south edges have no consumer.
    logic unused_edge;
    assign unused_edge = ^{a_w[i][LEN], b_w[LEN][i]};

    for (genvar j = 0; j < LEN; j++) begin : g_col
      systolic_pe #(
        .DEP  (DEP),
        .ACCW (ACCW)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .acc_en  (acc_en),
        .a       (a_w[i][j]),
        .b       (b_w[i][j]),
        .a_east  (a_w[i][j+1]),
        .b_south (b_w[i+1][j]),
        .acc     (acc_w[i][j])
`ifdef SYSTOLIC_MAC_SAT_EN
        ,
        .sat     (sat_bits[i*LEN+j])
`endif
      );
    end
  end

endmodule
